// File: rtl/mem_port_arb_pkg.sv
// Shared types and widths for the single-port memory arbiter.
// Contents: FSM state encoding, owner encoding, counter/data-port widths.
package mem_port_arb_pkg;

    localparam int unsigned CNT_W   = 4;   // wait-cycle counter width
    localparam int unsigned DADDR_W = 8;   // data-stage address width
    localparam int unsigned DDATA_W = 8;   // data-stage data width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_grant.sv
// Grant decision between the fetch and data-stage requesters.
// Default build: fixed priority, data stage wins.
// MEM_PORT_ARB_RR_EN: round-robin on ties, using a last-owner flop that resets
// to OWN_IF so the data stage wins the first tie.
// Ports:
//   clk, rst      clock / synchronous active-high reset (round-robin build only)
//   gnt_en_i      arbiter is able to accept a grant this cycle
//   if_req_i      fetch request
//   mem_req_i     data-stage request
//   gnt_c_o       a grant is issued this cycle (combinational)
//   gnt_own_c_o   owner being granted (combinational)
module arb_grant
    import mem_port_arb_pkg::*;
(
`ifdef MEM_PORT_ARB_RR_EN
    input  logic   clk,
    input  logic   rst,
    input  logic   gnt_en_i,
`endif
    input  logic   if_req_i,
    input  logic   mem_req_i,
    output logic   gnt_c_o,
    output owner_e gnt_own_c_o
);

    assign gnt_c_o = if_req_i | mem_req_i;

`ifdef MEM_PORT_ARB_RR_EN
    owner_e last_own_q;
    owner_e last_own_d;

    // On a tie, hand the port to whoever was not served last.
    always_comb begin
        gnt_own_c_o = OWN_MEM;
        if (if_req_i && mem_req_i) begin
            gnt_own_c_o = (last_own_q == OWN_MEM) ? OWN_IF : OWN_MEM;
        end else if (if_req_i) begin
            gnt_own_c_o = OWN_IF;
        end
    end

    always_comb begin
        last_own_d = last_own_q;
        if (gnt_en_i && gnt_c_o) begin
            last_own_d = gnt_own_c_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_own_q <= OWN_IF;
        end else begin
            last_own_q <= last_own_d;
        end
    end
`else
    // Fixed priority: the data stage always wins.
    assign gnt_own_c_o = mem_req_i ? OWN_MEM : OWN_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and the data stage.
// A transaction is IDLE (grant) -> BUSY for WAIT_CYCLES cycles -> DONE (valid
// pulse) -> IDLE. Optional macro MEM_PORT_ARB_RR_EN selects round-robin grant.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   if_req/if_addr                  fetch request and address
//   if_valid/if_rdata               fetch completion pulse and instruction
//   mem_req/mem_we/mem_addr/mem_wdata  data-stage request
//   mem_valid/mem_rdata             data completion pulse and read data
//   ext_en/ext_we/ext_addr/ext_wdata/ext_rdata  external memory port
//   stall_if/stall_mem              pipeline stalls (combinational)
module mem_port_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned IADDR_W     = 12,
    parameter int unsigned INST_W      = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [IADDR_W-1:0] if_addr,
    output logic               if_valid,
    output logic [INST_W-1:0]  if_rdata,
    input  logic               mem_req,
    input  logic               mem_we,
    input  logic [DADDR_W-1:0] mem_addr,
    input  logic [DDATA_W-1:0] mem_wdata,
    output logic               mem_valid,
    output logic [DDATA_W-1:0] mem_rdata,
    output logic               ext_en,
    output logic               ext_we,
    output logic [IADDR_W-1:0] ext_addr,
    output logic [INST_W-1:0]  ext_wdata,
    input  logic [INST_W-1:0]  ext_rdata,
    output logic               stall_if,
    output logic               stall_mem
);

    state_e             state_q,     state_d;
    owner_e             owner_q,     owner_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               ext_en_q,    ext_en_d;
    logic               ext_we_q,    ext_we_d;
    logic [IADDR_W-1:0] ext_addr_q,  ext_addr_d;
    logic [INST_W-1:0]  ext_wdata_q, ext_wdata_d;
    logic               if_valid_q,  if_valid_d;
    logic               mem_valid_q, mem_valid_d;
    logic [INST_W-1:0]  if_rdata_q,  if_rdata_d;
    logic [DDATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic   gnt_c;
    owner_e gnt_own_c;

    arb_grant u_arb_grant (
`ifdef MEM_PORT_ARB_RR_EN
        .clk         (clk),
        .rst         (rst),
        .gnt_en_i    (state_q == ST_IDLE),
`endif
        .if_req_i    (if_req),
        .mem_req_i   (mem_req),
        .gnt_c_o     (gnt_c),
        .gnt_own_c_o (gnt_own_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        ext_en_d    = ext_en_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_c) begin
                    owner_d  = gnt_own_c;
                    ext_en_d = 1'b1;
                    cnt_d    = CNT_W'(WAIT_CYCLES - 1);
                    state_d  = ST_BUSY;
                    if (gnt_own_c == OWN_MEM) begin
                        ext_we_d    = mem_we;
                        ext_addr_d  = IADDR_W'(mem_addr);
                        ext_wdata_d = INST_W'(mem_wdata);
                    end else begin
                        // Fetches never write, whatever mem_we is doing.
                        ext_we_d    = 1'b0;
                        ext_addr_d  = if_addr;
                        ext_wdata_d = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    // Last access cycle: capture read data and announce completion.
                    ext_en_d = 1'b0;
                    ext_we_d = 1'b0;
                    state_d  = ST_DONE;
                    if (owner_q == OWN_MEM) begin
                        mem_rdata_d = ext_rdata[DDATA_W-1:0];
                        mem_valid_d = 1'b1;
                    end else begin
                        if_rdata_d  = ext_rdata;
                        if_valid_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            ext_en_q    <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            ext_en_q    <= ext_en_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ext_en    = ext_en_q;
    assign ext_we    = ext_we_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;
    assign if_valid  = if_valid_q;
    assign mem_valid = mem_valid_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

    // Stalls must react in the same cycle as the request, hence combinational.
    assign stall_if  = if_req  & ~if_valid_q;
    assign stall_mem = mem_req & ~mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with WAIT_CYCLES=2.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [11:0] if_addr;
    logic        if_valid;
    logic [18:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_valid;
    logic [7:0]  mem_rdata;
    logic        ext_en;
    logic        ext_we;
    logic [11:0] ext_addr;
    logic [18:0] ext_wdata;
    logic [18:0] ext_rdata;
    logic        stall_if;
    logic        stall_mem;

    int n_pass   = 0;
    int n_checks = 0;

    mem_port_arbiter #(.WAIT_CYCLES(2), .IADDR_W(12), .INST_W(19)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .ext_en    (ext_en),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; mem_req = 1'b0; mem_we = 1'b1;
        if_addr = 12'hFFF; mem_addr = 8'hFF; mem_wdata = 8'hFF; ext_rdata = 19'h7FFFF;
        tick(); tick(); tick();
        n_checks++; if (ext_en !== 1'b0) $display("FAIL reset_ext_en got %b exp 0", ext_en); else n_pass++;
        n_checks++; if (ext_we !== 1'b0) $display("FAIL reset_ext_we got %b exp 0", ext_we); else n_pass++;
        n_checks++; if (ext_addr !== 12'h000) $display("FAIL reset_ext_addr got %h exp 000", ext_addr); else n_pass++;
        n_checks++; if (ext_wdata !== 19'h0) $display("FAIL reset_ext_wdata got %h exp 0", ext_wdata); else n_pass++;
        n_checks++; if (if_valid !== 1'b0 || mem_valid !== 1'b0) $display("FAIL reset_valid got %b%b exp 00", if_valid, mem_valid); else n_pass++;
        n_checks++; if (if_rdata !== 19'h0 || mem_rdata !== 8'h0) $display("FAIL reset_rdata got %h/%h exp 0/0", if_rdata, mem_rdata); else n_pass++;
        n_checks++; if (stall_if !== 1'b1) $display("FAIL reset_stall_if got %b exp 1", stall_if); else n_pass++;
        rst = 1'b0; if_req = 1'b0; mem_we = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        ext_rdata = 19'h12345; if_addr = 12'h00A; mem_we = 1'b1; if_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++; if (ext_en !== (k <= 2)) $display("FAIL fetch_ext_en k=%0d got %b exp %b", k, ext_en, (k <= 2)); else n_pass++;
            n_checks++; if (if_valid !== (k == 3)) $display("FAIL fetch_if_valid k=%0d got %b exp %b", k, if_valid, (k == 3)); else n_pass++;
            if (k <= 2) begin
                n_checks++; if (ext_addr !== 12'h00A) $display("FAIL fetch_ext_addr k=%0d got %h exp 00A", k, ext_addr); else n_pass++;
                n_checks++; if (ext_we !== 1'b0) $display("FAIL fetch_ext_we k=%0d got %b exp 0", k, ext_we); else n_pass++;
                n_checks++; if (stall_if !== 1'b1) $display("FAIL fetch_stall_if k=%0d got %b exp 1", k, stall_if); else n_pass++;
            end
            if (k == 3) begin
                n_checks++; if (if_rdata !== 19'h12345) $display("FAIL fetch_if_rdata got %h exp 12345", if_rdata); else n_pass++;
                n_checks++; if (stall_if !== 1'b0) $display("FAIL fetch_stall_if_done got %b exp 0", stall_if); else n_pass++;
                if_req = 1'b0;
            end
        end
        mem_we = 1'b0;
    endtask

    task automatic test_data_write();
        mem_we = 1'b1; mem_addr = 8'h3C; mem_wdata = 8'hA5; mem_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++; if (ext_we !== (k <= 2)) $display("FAIL write_ext_we k=%0d got %b exp %b", k, ext_we, (k <= 2)); else n_pass++;
            n_checks++; if (mem_valid !== (k == 3)) $display("FAIL write_mem_valid k=%0d got %b exp %b", k, mem_valid, (k == 3)); else n_pass++;
            if (k <= 2) begin
                n_checks++; if (ext_addr !== 12'h03C) $display("FAIL write_ext_addr k=%0d got %h exp 03C", k, ext_addr); else n_pass++;
                n_checks++; if (ext_wdata !== 19'h000A5) $display("FAIL write_ext_wdata k=%0d got %h exp 000A5", k, ext_wdata); else n_pass++;
            end
            if (k == 3) mem_req = 1'b0;
        end
        mem_we = 1'b0;
    endtask

    task automatic test_mem_read_drop();
        mem_we = 1'b0; mem_addr = 8'h55; ext_rdata = 19'h7FF5A; mem_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) mem_req = 1'b0;
            n_checks++; if (mem_valid !== (k == 3)) $display("FAIL read_mem_valid k=%0d got %b exp %b", k, mem_valid, (k == 3)); else n_pass++;
            if (k == 3) begin
                n_checks++; if (mem_rdata !== 8'h5A) $display("FAIL read_mem_rdata got %h exp 5A", mem_rdata); else n_pass++;
                n_checks++; if (if_rdata !== 19'h12345) $display("FAIL read_if_rdata_hold got %h exp 12345", if_rdata); else n_pass++;
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        if_addr = 12'h123; mem_addr = 8'h44; mem_we = 1'b0; ext_rdata = 19'h1ABCD;
        if_req = 1'b1; mem_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k <= 2) begin
                n_checks++; if (ext_addr !== 12'h044) $display("FAIL simul_mem_addr k=%0d got %h exp 044", k, ext_addr); else n_pass++;
            end
            if (k == 5 || k == 6) begin
                n_checks++; if (ext_addr !== 12'h123) $display("FAIL simul_if_addr k=%0d got %h exp 123", k, ext_addr); else n_pass++;
            end
            n_checks++; if (ext_en !== (k <= 2 || k == 5 || k == 6)) $display("FAIL simul_ext_en k=%0d got %b", k, ext_en); else n_pass++;
            n_checks++; if (mem_valid !== (k == 3)) $display("FAIL simul_mem_valid k=%0d got %b exp %b", k, mem_valid, (k == 3)); else n_pass++;
            n_checks++; if (if_valid !== (k == 7)) $display("FAIL simul_if_valid k=%0d got %b exp %b", k, if_valid, (k == 7)); else n_pass++;
            n_checks++; if (stall_if !== (k != 7 && k != 8)) $display("FAIL simul_stall_if k=%0d got %b", k, stall_if); else n_pass++;
            if (k == 1) begin
                n_checks++; if (stall_mem !== 1'b1) $display("FAIL simul_stall_mem got %b exp 1", stall_mem); else n_pass++;
            end
            if (k == 3) begin
                n_checks++; if (mem_rdata !== 8'hCD) $display("FAIL simul_mem_rdata got %h exp CD", mem_rdata); else n_pass++;
                n_checks++; if (stall_mem !== 1'b0) $display("FAIL simul_stall_mem_done got %b exp 0", stall_mem); else n_pass++;
                mem_req = 1'b0;
            end
            if (k == 7) begin
                n_checks++; if (if_rdata !== 19'h1ABCD) $display("FAIL simul_if_rdata got %h exp 1ABCD", if_rdata); else n_pass++;
                if_req = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        int got_own[4];
        int got_cyc[4];
        int exp_own;
        int n = 0;
        for (int i = 0; i < 4; i++) begin got_own[i] = -1; got_cyc[i] = -1; end
        do_reset();
        mem_we = 1'b0; mem_addr = 8'h10; if_addr = 12'h200;
        if_req = 1'b1; mem_req = 1'b1;
        for (int c = 1; c <= 24 && n < 4; c++) begin
            tick();
            if (if_valid === 1'b1 || mem_valid === 1'b1) begin
                got_own[n] = (mem_valid === 1'b1) ? 1 : 0;
                got_cyc[n] = c;
                n++;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        n_checks++; if (n !== 4) $display("FAIL b2b_count got %0d exp 4", n); else n_pass++;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_PORT_ARB_RR_EN
            exp_own = (i % 2 == 0) ? 1 : 0;
`else
            exp_own = 1;
`endif
            n_checks++; if (got_own[i] !== exp_own) $display("FAIL b2b_owner i=%0d got %0d exp %0d", i, got_own[i], exp_own); else n_pass++;
            n_checks++; if (got_cyc[i] !== 3 + 4 * i) $display("FAIL b2b_cycle i=%0d got %0d exp %0d", i, got_cyc[i], 3 + 4 * i); else n_pass++;
        end
        tick(); tick();
    endtask

    task automatic test_reset_abort();
        do_reset();
        if_addr = 12'h0F0; if_req = 1'b1;
        tick();
        n_checks++; if (ext_en !== 1'b1) $display("FAIL abort_busy_ext_en got %b exp 1", ext_en); else n_pass++;
        rst = 1'b1; if_req = 1'b0;
        tick();
        n_checks++; if (ext_en !== 1'b0) $display("FAIL abort_ext_en got %b exp 0", ext_en); else n_pass++;
        n_checks++; if (ext_addr !== 12'h000) $display("FAIL abort_ext_addr got %h exp 000", ext_addr); else n_pass++;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++; if (if_valid !== 1'b0 || ext_en !== 1'b0) $display("FAIL abort_quiet k=%0d got valid=%b en=%b exp 0/0", k, if_valid, ext_en); else n_pass++;
        end
        // A fresh request must see the normal latency, showing the FSM sits in IDLE.
        mem_we = 1'b1; mem_addr = 8'h01; mem_wdata = 8'h02; mem_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++; if (mem_valid !== (k == 3)) $display("FAIL abort_recover k=%0d got %b exp %b", k, mem_valid, (k == 3)); else n_pass++;
        end
        mem_req = 1'b0; mem_we = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_data_write();
        test_mem_read_drop();
        test_simultaneous();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
